// File: rtl/quad_enc_counter.sv
// Quadrature encoder front end: pin sync + glitch filter, x4 Gray decode, W-bit modular count with frame snapshot.
// Define ENC_INDEX_EN to build the index-pulse capture path (idx_pos_o / idx_seen_o); otherwise those outputs read 0.
module quad_enc_counter #(
  parameter int W   = 16,
  parameter int FLT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc_a_i,
  input  logic         enc_b_i,
  input  logic         enc_idx_i,
  input  logic         snap_i,
  input  logic         clr_i,
  output logic [W-1:0] count_snap_o,
  output logic [W-1:0] idx_pos_o,
  output logic         idx_seen_o,
  output logic         err_o
);

  localparam logic [3:0] FltLast = 4'(FLT - 1);

  // One filter step for a pin: returns {accepted level, next run count}.
  function automatic logic [4:0] filterStep(input logic syncLvl, input logic filtLvl,
                                            input logic [3:0] run);
    logic [4:0] res;
    res = {filtLvl, 4'd0};
    if (syncLvl != filtLvl) begin
      if (run >= FltLast) res = {syncLvl, 4'd0};
      else                res = {filtLvl, run + 4'd1};
    end
    return res;
  endfunction

  // Position of {A,B} along the A-leads-B sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] grayPos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  logic [1:0]   abS1_q, abS2_q, abFlt_q, abFlt_d;
  logic [3:0]   aRun_q, aRun_d, bRun_q, bRun_d;
  logic [W-1:0] count_q, count_d, countSnap_q;
  logic         err_q, errSet;
  logic [1:0]   posDelta;

  always_comb begin
    {abFlt_d[1], aRun_d} = filterStep(abS2_q[1], abFlt_q[1], aRun_q);
    {abFlt_d[0], bRun_d} = filterStep(abS2_q[0], abFlt_q[0], bRun_q);
    posDelta = grayPos(abFlt_d) - grayPos(abFlt_q);
    errSet   = (posDelta == 2'd2);
    count_d  = count_q;
    if (clr_i)                  count_d = '0;
    else if (posDelta == 2'd1)  count_d = count_q + W'(1);
    else if (posDelta == 2'd3)  count_d = count_q - W'(1);
  end

  // A set event in the same cycle as snap wins, so the frame after it still sees the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abS1_q      <= '0;
      abS2_q      <= '0;
      abFlt_q     <= '0;
      aRun_q      <= '0;
      bRun_q      <= '0;
      count_q     <= '0;
      countSnap_q <= '0;
      err_q       <= 1'b0;
    end else begin
      abS1_q  <= {enc_a_i, enc_b_i};
      abS2_q  <= abS1_q;
      abFlt_q <= abFlt_d;
      aRun_q  <= aRun_d;
      bRun_q  <= bRun_d;
      count_q <= count_d;
      if (snap_i) countSnap_q <= count_q;
      err_q   <= errSet | (err_q & ~snap_i);
    end
  end

  assign count_snap_o = countSnap_q;
  assign err_o        = err_q;

`ifdef ENC_INDEX_EN
  logic         idxS1_q, idxS2_q, idxFlt_q, idxFlt_d, idxRise;
  logic [3:0]   idxRun_q, idxRun_d;
  logic [W-1:0] idxPos_q;
  logic         idxSeen_q;

  always_comb begin
    {idxFlt_d, idxRun_d} = filterStep(idxS2_q, idxFlt_q, idxRun_q);
    idxRise = idxFlt_d & ~idxFlt_q;
  end

  // idx_pos takes the post-update count so a coincident step or clr is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idxS1_q   <= 1'b0;
      idxS2_q   <= 1'b0;
      idxFlt_q  <= 1'b0;
      idxRun_q  <= '0;
      idxPos_q  <= '0;
      idxSeen_q <= 1'b0;
    end else begin
      idxS1_q   <= enc_idx_i;
      idxS2_q   <= idxS1_q;
      idxFlt_q  <= idxFlt_d;
      idxRun_q  <= idxRun_d;
      if (idxRise) idxPos_q <= count_d;
      idxSeen_q <= idxRise | (idxSeen_q & ~snap_i);
    end
  end

  assign idx_pos_o  = idxPos_q;
  assign idx_seen_o = idxSeen_q;
`else
  logic unusedIdx;
  assign unusedIdx  = enc_idx_i;
  assign idx_pos_o  = '0;
  assign idx_seen_o = 1'b0;
`endif

endmodule

// File: tb/tb_quad_enc_counter.sv
// Directed testbench for quad_enc_counter: W=16 instance for the main behaviour, W=8 instance for the wrap/clr corner.
// Index expectations follow whether ENC_INDEX_EN is defined for the build.
module tb_quad_enc_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0, b = 1'b0, idx = 1'b0, snap = 1'b0, clr = 1'b0;
  logic [15:0] countSnap, idxPos;
  logic        idxSeen, err;

  logic        a8 = 1'b0, b8 = 1'b0, idx8 = 1'b0, snap8 = 1'b0, clr8 = 1'b0;
  logic [7:0]  countSnap8, idxPos8;
  logic        idxSeen8, err8;

  int checkCount = 0;
  int passCount  = 0;

  quad_enc_counter #(.W(16), .FLT(3)) dut (
    .clk(clk), .rst(rst), .enc_a_i(a), .enc_b_i(b), .enc_idx_i(idx),
    .snap_i(snap), .clr_i(clr), .count_snap_o(countSnap), .idx_pos_o(idxPos),
    .idx_seen_o(idxSeen), .err_o(err)
  );

  quad_enc_counter #(.W(8), .FLT(3)) dut8 (
    .clk(clk), .rst(rst), .enc_a_i(a8), .enc_b_i(b8), .enc_idx_i(idx8),
    .snap_i(snap8), .clr_i(clr8), .count_snap_o(countSnap8), .idx_pos_o(idxPos8),
    .idx_seen_o(idxSeen8), .err_o(err8)
  );

  always #5 clk = ~clk;

  // Hard stop so a stuck run still reports.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 500us");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive new A/B levels right after an edge, then hold them for holdClk cycles.
  task automatic applyStimulus(input logic newA, input logic newB, input int holdClk);
    a = newA;
    b = newB;
    repeat (holdClk) tick();
  endtask

  task automatic fwdStep(input int holdClk);
    applyStimulus(~b, a, holdClk);
  endtask

  task automatic revStep(input int holdClk);
    applyStimulus(b, ~a, holdClk);
  endtask

  task automatic doSnap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic doSnap8();
    snap8 = 1'b1;
    tick();
    snap8 = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) tick();
    checkOutput("rst_countSnap", 32'(countSnap), 32'h0);
    checkOutput("rst_idxPos", 32'(idxPos), 32'h0);
    checkOutput("rst_idxSeen", 32'(idxSeen), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();

    // Count to 37, then pull reset mid-operation with the pins returned low.
    repeat (37) fwdStep(6);
    doSnap();
    checkOutput("pre_rst_count", 32'(countSnap), 32'd37);
    rst = 1'b1;
    a = 1'b0;
    b = 1'b0;
    tick();
    checkOutput("midrst_countSnap", 32'(countSnap), 32'h0);
    checkOutput("midrst_idxPos", 32'(idxPos), 32'h0);
    checkOutput("midrst_idxSeen", 32'(idxSeen), 32'h0);
    checkOutput("midrst_err", 32'(err), 32'h0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    doSnap();
    checkOutput("postrst_count", 32'(countSnap), 32'h0);
    checkOutput("postrst_err", 32'(err), 32'h0);

    // 0 - 1 wraps to all ones, then step back to zero.
    revStep(10);
    doSnap();
    checkOutput("zero_minus_one", 32'(countSnap), 32'hFFFF);
    fwdStep(10);

    // First forward edge launched after edge 0 lands on edge 5: snap at edge 5 sees old, at edge 6 sees new.
    a = 1'b1;
    repeat (4) tick();
    snap = 1'b1;
    tick();
    checkOutput("latency_edge4", 32'(countSnap), 32'h0);
    tick();
    checkOutput("latency_edge5", 32'(countSnap), 32'h1);
    snap = 1'b0;
    repeat (4) tick();
    repeat (31) fwdStep(10);
    doSnap();
    checkOutput("fwd_32", 32'(countSnap), 32'd32);
    repeat (40) revStep(10);
    doSnap();
    checkOutput("rev_40", 32'(countSnap), 32'hFFF8);
    checkOutput("fwdrev_err", 32'(err), 32'h0);

    // Glitches: 2-clk pulse rejected, 3-clk pulse counts up then down.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 10);
    doSnap();
    checkOutput("glitch2_count", 32'(countSnap), 32'hFFF8);
    checkOutput("glitch2_err", 32'(err), 32'h0);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    doSnap();
    checkOutput("glitch3_count", 32'(countSnap), 32'hFFF8);
    checkOutput("glitch3_err", 32'(err), 32'h0);

    // Illegal 00 -> 11: count held, err sticky until snap.
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("illegal_err_set", 32'(err), 32'h1);
    doSnap();
    checkOutput("illegal_count_held", 32'(countSnap), 32'hFFF8);
    checkOutput("illegal_err_cleared", 32'(err), 32'h0);
    doSnap();
    checkOutput("idle_snap_err", 32'(err), 32'h0);

    // Illegal 11 -> 00 accepted on the same edge as a snap: err survives.
    a = 1'b0;
    b = 1'b0;
    repeat (4) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    checkOutput("illegal_with_snap_err", 32'(err), 32'h1);
    checkOutput("illegal_with_snap_count", 32'(countSnap), 32'hFFF8);
    repeat (5) tick();
    doSnap();
    checkOutput("after_coincident_err", 32'(err), 32'h0);

    // Index rise together with a +1 step: idx_pos includes the step.
    idx = 1'b1;
    fwdStep(10);
`ifdef ENC_INDEX_EN
    checkOutput("idx_pos", 32'(idxPos), 32'hFFF9);
    checkOutput("idx_seen_set", 32'(idxSeen), 32'h1);
`else
    checkOutput("idx_pos_tied", 32'(idxPos), 32'h0);
    checkOutput("idx_seen_tied", 32'(idxSeen), 32'h0);
`endif
    doSnap();
    checkOutput("idx_snap_count", 32'(countSnap), 32'hFFF9);
    checkOutput("idx_seen_cleared", 32'(idxSeen), 32'h0);
    idx = 1'b0;
    repeat (10) tick();
    checkOutput("idx_fall_ignored", 32'(idxSeen), 32'h0);

    // W=8 instance: 127 -> 128 wraps to -128, then clr beats a same-cycle step.
    repeat (127) begin
      {a8, b8} = {~b8, a8};
      repeat (4) tick();
    end
    repeat (4) tick();
    doSnap8();
    checkOutput("w8_max_pos", 32'(countSnap8), 32'h7F);
    {a8, b8} = {~b8, a8};
    repeat (6) tick();
    doSnap8();
    checkOutput("w8_wrap", 32'(countSnap8), 32'h80);
    {a8, b8} = {~b8, a8};
    repeat (4) tick();
    clr8  = 1'b1;
    snap8 = 1'b1;
    tick();
    clr8  = 1'b0;
    snap8 = 1'b0;
    checkOutput("w8_clr_snap_old", 32'(countSnap8), 32'h80);
    repeat (3) tick();
    doSnap8();
    checkOutput("w8_clr_wins", 32'(countSnap8), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
